// File: rtl/controle_recarga_tiro.sv
// Shot-charge controller in front of a 16x2-bit RAM: init, fire and periodic refill sweeps.
// Optional shot counter output db_total_tiros is enabled by defining CONTADOR_TIROS_EN.
module controle_recarga_tiro #(
  parameter int CARGA_MAX      = 2,
  parameter int RECARGA_CICLOS = 50000,
  parameter int TIMER_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pedido_tiro,
  input  logic [3:0] slot,
  output logic       mem_we,
  output logic [3:0] mem_addr,
  output logic [1:0] mem_data,
  input  logic [1:0] mem_q,
  output logic       pronto,
  output logic       ocupado,
  output logic       tiro_ok,
  output logic       tiro_negado,
  output logic [1:0] carga_atual
`ifdef CONTADOR_TIROS_EN
  ,
  output logic [7:0] db_total_tiros
`endif
);

  localparam logic [1:0] L_MAX = 2'(CARGA_MAX);
  localparam logic [TIMER_W-1:0] L_TOP =
    TIMER_W'(RECARGA_CICLOS - 1);

  typedef enum logic [2:0] {
    INICIAL,
    OCIOSO,
    LE_TIRO,
    ESCREVE_TIRO,
    LE_RECARGA,
    ESCREVE_RECARGA
  } estado_t;

  estado_t            r_estado;
  logic [3:0]         r_idx;
  logic [3:0]         r_slot;
  logic [TIMER_W-1:0] r_timer;
  logic               r_pend;
  logic               r_da_recarga;
  logic               r_pronto;
  logic               r_tiro_ok;
  logic               r_tiro_negado;
  logic [1:0]         r_carga;

  logic       w_we;
  logic [3:0] w_addr;
  logic [1:0] w_data;
  logic       w_expira;
  logic       w_inicia;

  assign w_expira = r_pronto && (r_timer == L_TOP);
  assign w_inicia = (r_estado == OCIOSO) &&
                    !pedido_tiro && r_pend;

  // RAM write path follows mem_q in the same cycle
  always_comb begin
    w_we   = 1'b0;
    w_addr = r_idx;
    w_data = L_MAX;
    unique case (r_estado)
      INICIAL: w_we = 1'b1;
      LE_TIRO: w_addr = r_slot;
      ESCREVE_TIRO: begin
        w_addr = r_slot;
        w_we   = (mem_q != 2'd0);
        w_data = mem_q - 2'd1;
      end
      ESCREVE_RECARGA: begin
        w_we   = (mem_q < L_MAX);
        w_data = mem_q + 2'd1;
      end
      default: ;
    endcase
  end

  assign mem_we   = w_we & ~reset;
  assign mem_addr = w_addr;
  assign mem_data = w_data;

  assign pronto      = r_pronto;
  assign ocupado     = !((r_estado == OCIOSO) ||
                         (r_estado == ESCREVE_RECARGA));
  assign tiro_ok     = r_tiro_ok;
  assign tiro_negado = r_tiro_negado;
  assign carga_atual = r_carga;

`ifdef CONTADOR_TIROS_EN
  logic [7:0] r_tiros;
  assign db_total_tiros = r_tiros;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado      <= INICIAL;
      r_idx         <= 4'd0;
      r_slot        <= 4'd0;
      r_timer       <= '0;
      r_pend        <= 1'b0;
      r_da_recarga  <= 1'b0;
      r_pronto      <= 1'b0;
      r_tiro_ok     <= 1'b0;
      r_tiro_negado <= 1'b0;
      r_carga       <= 2'd0;
`ifdef CONTADOR_TIROS_EN
      r_tiros       <= 8'd0;
`endif
    end else begin
      r_tiro_ok     <= 1'b0;
      r_tiro_negado <= 1'b0;

      if (r_pronto) begin
        if (r_timer == L_TOP) r_timer <= '0;
        else r_timer <= r_timer + TIMER_W'(1);
      end

      // a fresh expiry wins over the clear of the one being consumed
      if (w_expira) r_pend <= 1'b1;
      else if (w_inicia) r_pend <= 1'b0;

      unique case (r_estado)
        INICIAL: begin
          if (r_idx == 4'd15) begin
            r_idx    <= 4'd0;
            r_pronto <= 1'b1;
            r_estado <= OCIOSO;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        OCIOSO: begin
          if (pedido_tiro) begin
            r_slot       <= slot;
            r_da_recarga <= 1'b0;
            r_estado     <= LE_TIRO;
          end else if (r_pend) begin
            r_idx    <= 4'd0;
            r_estado <= LE_RECARGA;
          end
        end
        LE_TIRO: r_estado <= ESCREVE_TIRO;
        ESCREVE_TIRO: begin
          r_carga <= mem_q;
          if (mem_q != 2'd0) begin
            r_tiro_ok <= 1'b1;
`ifdef CONTADOR_TIROS_EN
            if (r_tiros != 8'hFF)
              r_tiros <= r_tiros + 8'd1;
`endif
          end else begin
            r_tiro_negado <= 1'b1;
          end
          r_estado <= r_da_recarga ? LE_RECARGA : OCIOSO;
        end
        LE_RECARGA: r_estado <= ESCREVE_RECARGA;
        ESCREVE_RECARGA: begin
          if (r_idx == 4'd15) begin
            r_idx    <= 4'd0;
            r_estado <= OCIOSO;
          end else begin
            r_idx <= r_idx + 4'd1;
            if (pedido_tiro) begin
              r_slot       <= slot;
              r_da_recarga <= 1'b1;
              r_estado     <= LE_TIRO;
            end else begin
              r_estado <= LE_RECARGA;
            end
          end
        end
        default: r_estado <= INICIAL;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_recarga_tiro.sv
// Scoreboard bench: stimulus queues expected RAM writes and shot results,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_controle_recarga_tiro;

  logic       clk;
  logic       reset;
  logic       pedido_tiro;
  logic [3:0] slot;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [1:0] mem_data;
  logic [1:0] mem_q;
  logic       pronto;
  logic       ocupado;
  logic       tiro_ok;
  logic       tiro_negado;
  logic [1:0] carga_atual;
`ifdef CONTADOR_TIROS_EN
  logic [7:0] db_total_tiros;
`endif

  controle_recarga_tiro #(
    .CARGA_MAX(2),
    .RECARGA_CICLOS(100),
    .TIMER_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pedido_tiro(pedido_tiro),
    .slot(slot),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mem_q(mem_q),
    .pronto(pronto),
    .ocupado(ocupado),
    .tiro_ok(tiro_ok),
    .tiro_negado(tiro_negado),
    .carga_atual(carga_atual)
`ifdef CONTADOR_TIROS_EN
    ,
    .db_total_tiros(db_total_tiros)
`endif
  );

  typedef struct {
    logic [3:0] a;
    logic [1:0] d;
    int         c;
  } wr_t;

  typedef struct {
    bit         ok;
    logic [1:0] q;
    int         c;
  } rs_t;

  wr_t wq[$];
  rs_t rq[$];
  wr_t we_e;
  rs_t rs_e;

  logic [1:0] ram [16];
  logic [1:0] exp_mem [16];
  int cyc = 0;
  int R = 0;
  int n_checks = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 16; i++)
      ram[i] = 2'($urandom_range(0, 3));
  end

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_data;
    mem_q <= ram[mem_addr];
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      if (wq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data %0d cycle %0d expected none",
                 mem_addr, mem_data, cyc);
      end else begin
        we_e = wq.pop_front();
        chk("wr_addr", int'(mem_addr), int'(we_e.a));
        chk("wr_data", int'(mem_data), int'(we_e.d));
        chk("wr_cycle", cyc, we_e.c);
      end
    end
    if (tiro_ok || tiro_negado) begin
      if (rq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: ok %0d negado %0d cycle %0d expected none",
                 tiro_ok, tiro_negado, cyc);
      end else begin
        rs_e = rq.pop_front();
        chk("pulse_ok", int'(tiro_ok), int'(rs_e.ok));
        chk("pulse_negado", int'(tiro_negado), int'(!rs_e.ok));
        chk("carga_atual", int'(carga_atual), int'(rs_e.q));
        chk("pulse_cycle", cyc, rs_e.c);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic expect_fire(input logic [3:0] s, input int c);
    rs_t r;
    wr_t w;
    r.ok = (exp_mem[s] != 2'd0);
    r.q  = exp_mem[s];
    r.c  = c + 3;
    rq.push_back(r);
    if (r.ok) begin
      w.a = s;
      w.d = exp_mem[s] - 2'd1;
      w.c = c + 2;
      wq.push_back(w);
      exp_mem[s] = w.d;
    end
  endtask

  task automatic fire_now(input logic [3:0] s);
    chk("accept_idle", int'(ocupado), 0);
    pedido_tiro = 1'b1;
    slot = s;
    expect_fire(s, cyc);
    step();
    pedido_tiro = 1'b0;
    slot = ~s;
  endtask

  task automatic fire_idle(input logic [3:0] s);
    int k = 0;
    while (ocupado && k < 200) begin
      step();
      k++;
    end
    fire_now(s);
  endtask

  task automatic push_sweep(input int lo, input int hi,
                            input int base);
    wr_t w;
    for (int i = lo; i <= hi; i++) begin
      if (exp_mem[i] < 2'd2) begin
        w.a = 4'(i);
        w.d = exp_mem[i] + 2'd1;
        w.c = base + 2 * i;
        wq.push_back(w);
        exp_mem[i] = w.d;
      end
    end
  endtask

  task automatic do_reset(input int n);
    wr_t w;
    reset = 1'b1;
    pedido_tiro = 1'b0;
    @(negedge clk);
    chk("we_in_reset", int'(mem_we), 0);
    repeat (n) step();
    @(negedge clk);
    chk("rst_pronto", int'(pronto), 0);
    chk("rst_ocupado", int'(ocupado), 1);
    chk("rst_tiro_ok", int'(tiro_ok), 0);
    chk("rst_tiro_negado", int'(tiro_negado), 0);
    chk("rst_carga", int'(carga_atual), 0);
    chk("rst_we", int'(mem_we), 0);
`ifdef CONTADOR_TIROS_EN
    chk("rst_total", int'(db_total_tiros), 0);
`endif
    step();
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    reset = 1'b0;
    R = cyc;
    for (int i = 0; i < 16; i++) begin
      w.a = 4'(i);
      w.d = 2'd2;
      w.c = R + i;
      wq.push_back(w);
      exp_mem[i] = 2'd2;
    end
  endtask

  task automatic chk_ram(input string nm);
    for (int i = 0; i < 16; i++)
      chk(nm, int'(ram[i]), int'(exp_mem[i]));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    pedido_tiro = 1'b0;
    slot = 4'd0;

    // init sweep, then three shots on slot 5 and a busy drop
    do_reset(4);
    wait_until(R + 15);
    chk("pronto_before", int'(pronto), 0);
    step();
    chk("pronto_after", int'(pronto), 1);
    chk("idle_after_init", int'(ocupado), 0);
    for (int i = 0; i < 16; i++)
      chk("ram_init", int'(ram[i]), 2);
    fire_now(4'd5);
    fire_idle(4'd5);
    fire_idle(4'd5);
    fire_idle(4'd9);
    chk("busy_le", int'(ocupado), 1);
    pedido_tiro = 1'b1;
    slot = 4'd2;
    step();
    pedido_tiro = 1'b0;
    step();
    step();
    wait_until(cyc + 4);
    chk("slot5_empty", int'(ram[5]), 0);
    chk("slot9_one", int'(ram[9]), 1);
    chk("slot2_kept", int'(ram[2]), 2);
    chk("carga_last", int'(carga_atual), 2);
`ifdef CONTADOR_TIROS_EN
    chk("total_p1", int'(db_total_tiros), 3);
`endif

    // refill sweep with only slot 3 below full
    do_reset(2);
    wait_until(R + 16);
    fire_now(4'd3);
    fire_idle(4'd3);
    push_sweep(0, 15, R + 118);
    wait_until(R + 116);
    chk("pre_sweep_idle", int'(ocupado), 0);
    step();
    chk("sweep_le0", int'(ocupado), 1);
    wait_until(R + 147);
    chk("sweep_le15", int'(ocupado), 1);
    wait_until(R + 149);
    chk("slot3_refilled", int'(ram[3]), 1);
    chk_ram("ram_after_sweep");
    fire_now(4'd3);
    wait_until(R + 156);

    // shot interleaved into the sweep at index 4
    do_reset(2);
    wait_until(R + 16);
    fire_now(4'd2);
    fire_idle(4'd4);
    fire_idle(4'd5);
    fire_idle(4'd7);
    fire_idle(4'd15);
    push_sweep(0, 4, R + 118);
    wait_until(R + 126);
    fire_now(4'd7);
    push_sweep(5, 15, R + 120);
    wait_until(R + 149);
    chk("shifted_le15", int'(ocupado), 1);
    wait_until(R + 151);
    chk("shifted_end", int'(ocupado), 0);
    step();
    chk_ram("ram_interleave");

    // reset mid-sweep at index 9
    do_reset(2);
    wait_until(R + 16);
    fire_now(4'd3);
    fire_idle(4'd9);
    push_sweep(0, 8, R + 118);
    wait_until(R + 136);
    chk("esc9_idle", int'(ocupado), 0);
`ifdef CONTADOR_TIROS_EN
    chk("total_p4", int'(db_total_tiros), 2);
`endif
    do_reset(3);
    wait_until(R + 17);
    chk_ram("ram_reinit");
    step();
    chk("wq_end", wq.size(), 0);
    chk("rq_end", rq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/controle_recarga_tiro.md
Name: controle_recarga_tiro

Overview:
- Controller directly upstream of the 16x2-bit shot-charge RAM. It drives that RAM's write-enable, data and address inputs, and consumes its read-data output.
- Each of the 16 slots is one shot channel holding a 2-bit charge level.
- On a fire request: reads the addressed slot, decrements the charge if non-zero, and reports accept/deny.
- A periodic timer triggers a sweep that tops up every slot by one, saturating at CARGA_MAX.
- After reset, an initialisation sweep writes CARGA_MAX to all slots, so RAM contents are defined regardless of power-up state.

Parameters:
- CARGA_MAX, 2, full charge level per slot; range 1..3.
- RECARGA_CICLOS, 50000, clock cycles between refill sweeps; must be >= 2.
- TIMER_W, 16, timer width; must satisfy 2^TIMER_W >= RECARGA_CICLOS.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pedido_tiro  in  1  fire request; sampled only when ocupado=0.
- slot  in  4  slot to fire from; sampled together with pedido_tiro.
- mem_we  out  1  RAM write enable.
- mem_addr  out  4  RAM address.
- mem_data  out  2  RAM write data.
- mem_q  in  2  RAM read data; valid the cycle after mem_addr is presented.
- pronto  out  1  high once the init sweep has finished.
- ocupado  out  1  high when a new request cannot be accepted.
- tiro_ok  out  1  one-cycle pulse: shot accepted.
- tiro_negado  out  1  one-cycle pulse: slot was empty, shot denied.
- carga_atual  out  2  charge read at the last fire request, before any decrement.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset values:
  - state=INICIAL, sweep index=0, timer=0, recarga_pendente=0.
  - pronto=0, ocupado=1, tiro_ok=0, tiro_negado=0, carga_atual=0.
  - mem_we=0 in any cycle where reset=1.
- INICIAL:
  - mem_we=1, mem_addr=index, mem_data=CARGA_MAX; index increments each cycle.
  - After index 15 is written (16 cycles): index clears, go to OCIOSO, pronto goes to 1.
- OCIOSO (ocupado=0):
  - pedido_tiro=1: latch slot, go to LE_TIRO. This has priority over a pending sweep.
  - Else if recarga_pendente=1: clear it, index=0, go to LE_RECARGA.
- LE_TIRO:
  - mem_addr=latched slot, mem_we=0. Go to ESCREVE_TIRO.
- ESCREVE_TIRO (mem_q valid):
  - carga_atual<=mem_q.
  - If mem_q!=0: mem_we=1, mem_data=mem_q-1, and register tiro_ok.
  - If mem_q=0: no write, and register tiro_negado.
  - Return to OCIOSO, or to LE_RECARGA if entered from a sweep.
- Fire latency:
  - Request accepted in cycle C gives LE_TIRO in C+1, ESCREVE_TIRO in C+2.
  - The tiro_ok or tiro_negado pulse is high for exactly cycle C+3.
- LE_RECARGA:
  - mem_addr=index. Go to ESCREVE_RECARGA.
- ESCREVE_RECARGA (ocupado=0):
  - mem_we=1 only if mem_q<CARGA_MAX, with mem_data=mem_q+1. Slots already at or above CARGA_MAX are not written.
  - If index=15: index clears, go to OCIOSO.
  - Else index increments. If pedido_tiro=1 this cycle, service the fire (LE_TIRO, ESCREVE_TIRO) and then resume LE_RECARGA at the new index. Otherwise go to LE_RECARGA.
- Sweep timing:
  - A full uninterrupted sweep takes 32 cycles; each interleaved fire adds 2 cycles.
- Timer:
  - Counts only while pronto=1.
  - On reaching RECARGA_CICLOS-1: wraps to 0 and sets recarga_pendente.
  - Further expiries while the flag is already set are absorbed; at most one sweep is queued.
- Requests while busy:
  - Requests seen while ocupado=1 are dropped, not queued.
  - slot changes after sampling have no effect on the shot in progress.
- Arithmetic:
  - All 2-bit arithmetic is unsigned.
  - A decrement is never issued at 0; an increment is never issued at CARGA_MAX. No wrap-around is possible.
- Reset mid-operation: the write in progress is dropped, the init sweep restarts, and any pending refill is cleared.

Optional Feature:
- Macro: CONTADOR_TIROS_EN.
- When defined:
  - Adds output db_total_tiros, 8 bits.
  - Increments on each tiro_ok pulse and saturates at 255.
  - Resets to 0.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, hold 20 cycles → mem_we=1 for exactly 16 consecutive cycles on addr 0..15 with data 2; pronto=1 after the 16th; every slot then reads 2.
- Fire slot 5 three times, CARGA_MAX=2 → carga_atual 2, 1, 0; pulses tiro_ok, tiro_ok, tiro_negado; slot 5 ends at 0; each pulse lands 3 cycles after acceptance.
- RECARGA_CICLOS=100, empty slot 3, wait for the sweep → slot 3=1, other slots stay 2 with no write issued; sweep completes in 32 cycles.
- Assert pedido_tiro (slot 7) in the ESCREVE_RECARGA cycle for index 4 → shot serviced, then sweep resumes at index 5; all 16 slots visited exactly once.
- Pulse pedido_tiro while ocupado=1 (during LE_TIRO) → request ignored, exactly one result pulse.
- Assert reset during a sweep at index 9 → no write that cycle; init sweep rewrites all slots to 2; with CONTADOR_TIROS_EN, db_total_tiros returns to 0.
